// File: rtl/usb_pkg.sv
// Shared USB receive-path types and constants.
package usb_pkg;

  typedef enum logic [1:0] {
    LS_J,
    LS_K,
    LS_SE0,
    LS_SE1
  } line_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_SYNC,
    RX_DATA,
    RX_EOP,
    RX_ERROR
  } rx_state_t;

  localparam int USB_SYNC_BITS   = 8;
  localparam int USB_STUFF_LIMIT = 6;

endpackage

// File: rtl/usb_nrzi_decoder.sv
// Line-state classification and NRZI decode, advanced once per bit-centre strobe.
module usb_nrzi_decoder
  import usb_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        sample_en,
  input  logic        dp_in,
  input  logic        dm_in,
  output line_state_t ls_o,
  output line_state_t prev_ls_o,
  output logic        nrzi_bit_o
);

  line_state_t ls;
  line_state_t prev_ls_q;

  // Full-speed polarity: J is D+ high, K is D- high.
  always_comb begin
    ls = LS_SE0;
    case ({dp_in, dm_in})
      2'b10:   ls = LS_J;
      2'b01:   ls = LS_K;
      2'b00:   ls = LS_SE0;
      default: ls = LS_SE1;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      prev_ls_q <= LS_J;
    end else if (sample_en) begin
      prev_ls_q <= ls;
    end
  end

  assign ls_o       = ls;
  assign prev_ls_o  = prev_ls_q;
  assign nrzi_bit_o = (ls == prev_ls_q);

endmodule

// File: rtl/usb_rx_bit_recovery.sv
// USB full-speed receive bit recovery: SYNC detect, destuffing, EOP and error detection.
module usb_rx_bit_recovery
  import usb_pkg::*;
#(
  parameter int STUFF_LIMIT  = USB_STUFF_LIMIT,
  parameter int IDLE_RECOVER = 8
) (
  input  logic CLK,
  input  logic nRST,
  input  logic sample_en,
  input  logic dp_in,
  input  logic dm_in,
  output logic bit_valid,
  output logic bit_data,
  output logic rx_active,
  output logic sync_done,
  output logic eop_detected,
  output logic stuff_error
);

  localparam int JW = $clog2(IDLE_RECOVER + 1);

  line_state_t ls, prevLs;
  logic        nrziBit, isJK;

  rx_state_t   state_q, state_d;
  logic [2:0]  syncCnt_q, syncCnt_d;
  logic [2:0]  onesCnt_q, onesCnt_d;
  logic [1:0]  se0Cnt_q, se0Cnt_d;
  logic [JW-1:0] jCnt_q, jCnt_d;

  logic bitValid_q, bitValid_d, bitData_q, bitData_d;
  logic syncDone_q, syncDone_d, eop_q, eop_d;
  logic stuffErr_q, stuffErr_d, rxActive_q, rxActive_d;

  usb_nrzi_decoder u_nrzi (
    .CLK        (CLK),
    .nRST       (nRST),
    .sample_en  (sample_en),
    .dp_in      (dp_in),
    .dm_in      (dm_in),
    .ls_o       (ls),
    .prev_ls_o  (prevLs),
    .nrzi_bit_o (nrziBit)
  );

  assign isJK = (ls == LS_J) || (ls == LS_K);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= RX_IDLE;
      syncCnt_q  <= '0;
      onesCnt_q  <= '0;
      se0Cnt_q   <= '0;
      jCnt_q     <= '0;
      bitValid_q <= 1'b0;
      bitData_q  <= 1'b0;
      syncDone_q <= 1'b0;
      eop_q      <= 1'b0;
      stuffErr_q <= 1'b0;
      rxActive_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      syncCnt_q  <= syncCnt_d;
      onesCnt_q  <= onesCnt_d;
      se0Cnt_q   <= se0Cnt_d;
      jCnt_q     <= jCnt_d;
      bitValid_q <= bitValid_d;
      bitData_q  <= bitData_d;
      syncDone_q <= syncDone_d;
      eop_q      <= eop_d;
      stuffErr_q <= stuffErr_d;
      rxActive_q <= rxActive_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    syncCnt_d = syncCnt_q;
    onesCnt_d = onesCnt_q;
    se0Cnt_d  = se0Cnt_q;
    jCnt_d    = jCnt_q;
    if (sample_en) begin
      case (state_q)
        RX_IDLE: begin
          if (ls == LS_K) begin
            state_d   = RX_SYNC;
            syncCnt_d = 3'd1;
          end
        end
        RX_SYNC: begin
          if (!isJK) begin
            state_d = RX_IDLE;
          end else if (syncCnt_q == 3'(USB_SYNC_BITS - 1)) begin
            state_d   = nrziBit ? RX_DATA : RX_IDLE;
            onesCnt_d = '0;
          end else if (!nrziBit) begin
            syncCnt_d = syncCnt_q + 3'd1;
          end else begin
            state_d = RX_IDLE;
          end
        end
        RX_DATA: begin
          if (isJK) begin
            // At the limit the next bit is a stuff bit and must be a 0.
            if (onesCnt_q == 3'(STUFF_LIMIT)) begin
              if (nrziBit) state_d = RX_ERROR;
              else         onesCnt_d = '0;
            end else begin
              onesCnt_d = nrziBit ? onesCnt_q + 3'd1 : 3'd0;
            end
          end else if (ls == LS_SE0) begin
            state_d  = RX_EOP;
            se0Cnt_d = 2'd1;
          end else begin
            state_d = RX_ERROR;
          end
        end
        RX_EOP: begin
          if (ls == LS_SE0) begin
            se0Cnt_d = se0Cnt_q + 2'd1;
            if (se0Cnt_q >= 2'd2) state_d = RX_ERROR;
          end else if (ls == LS_J) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_ERROR;
          end
        end
        RX_ERROR: begin
          if (ls == LS_J) begin
            if (prevLs == LS_SE0 || jCnt_q == JW'(IDLE_RECOVER - 1)) begin
              state_d = RX_IDLE;
              jCnt_d  = '0;
            end else begin
              jCnt_d = jCnt_q + 1'b1;
            end
          end else begin
            jCnt_d = '0;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    bitValid_d = sample_en && state_q == RX_DATA && isJK && onesCnt_q != 3'(STUFF_LIMIT);
    bitData_d  = bitValid_d && nrziBit;
    syncDone_d = sample_en && state_q == RX_SYNC && state_d == RX_DATA;
    eop_d      = sample_en && state_q == RX_EOP && state_d == RX_IDLE;
    stuffErr_d = sample_en && state_q != RX_ERROR && state_d == RX_ERROR;
    rxActive_d = rxActive_q;
    if (syncDone_d)          rxActive_d = 1'b1;
    if (eop_d || stuffErr_d) rxActive_d = 1'b0;
  end

  assign bit_valid    = bitValid_q;
  assign bit_data     = bitData_q;
  assign sync_done    = syncDone_q;
  assign eop_detected = eop_q;
  assign stuff_error  = stuffErr_q;
  assign rx_active    = rxActive_q;

endmodule

// File: tb/tb_usb_rx_bit_recovery.sv
// Directed scoreboard bench for usb_rx_bit_recovery.
module tb_usb_rx_bit_recovery;
  import usb_pkg::*;

  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic sample_en = 1'b0;
  logic dp_in = 1'b1;
  logic dm_in = 1'b0;
  logic bit_valid, bit_data, rx_active, sync_done, eop_detected, stuff_error;

  int compared = 0;
  int mismatched = 0;
  logic [5:0] expQ[$];
  logic [1:0] lvl = LJ;

  usb_rx_bit_recovery dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .sample_en    (sample_en),
    .dp_in        (dp_in),
    .dm_in        (dm_in),
    .bit_valid    (bit_valid),
    .bit_data     (bit_data),
    .rx_active    (rx_active),
    .sync_done    (sync_done),
    .eop_detected (eop_detected),
    .stuff_error  (stuff_error)
  );

  always #5 CLK = ~CLK;

  // Observed vector: {bit_valid, bit_data, sync_done, eop_detected, stuff_error, rx_active}
  function automatic logic [5:0] obsVec();
    return {bit_valid, bit_data, sync_done, eop_detected, stuff_error, rx_active};
  endfunction

  task automatic checkValue(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [5:0] exp;
    if (expQ.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=<empty queue>", tag, obsVec());
    end else begin
      exp = expQ.pop_front();
      checkValue(tag, obsVec(), exp);
    end
  endtask

  // One strobe, then gap-1 idle cycles in which every pulse must be low.
  task automatic applyStimulus(input logic [1:0] ls, input logic [5:0] exp, input int gap, input string tag);
    dp_in = ls[1];
    dm_in = ls[0];
    sample_en = 1'b1;
    expQ.push_back(exp);
    @(posedge CLK);
    #1;
    sample_en = 1'b0;
    checkOutput(tag);
    for (int g = 1; g < gap; g++) begin
      @(posedge CLK);
      #1;
      checkValue({tag, "_gap"}, obsVec(), {5'b0, exp[0]});
    end
  endtask

  function automatic logic [1:0] flip(input logic [1:0] l);
    return (l == LJ) ? LK : LJ;
  endfunction

  task automatic sendSync(input int gap, input string tag);
    for (int i = 0; i < 7; i++) begin
      lvl = (i % 2 == 0) ? LK : LJ;
      applyStimulus(lvl, 6'b000000, gap, tag);
    end
    lvl = LK;
    applyStimulus(lvl, 6'b001001, gap, {tag, "_done"});
  endtask

  // NRZI-encodes a byte LSB-first, inserting a stuffed 0 after six 1s.
  task automatic sendByte(input logic [7:0] b, input int gap, input string tag);
    int ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (ones == 6) begin
        lvl = flip(lvl);
        applyStimulus(lvl, 6'b000001, gap, {tag, "_stuff"});
        ones = 0;
      end
      if (b[i]) ones++;
      else begin
        lvl = flip(lvl);
        ones = 0;
      end
      applyStimulus(lvl, {1'b1, b[i], 4'b0001}, gap, tag);
    end
    if (ones == 6) begin
      lvl = flip(lvl);
      applyStimulus(lvl, 6'b000001, gap, {tag, "_stuff"});
    end
  endtask

  task automatic sendEop(input int gap, input string tag);
    applyStimulus(LSE0, 6'b000001, gap, tag);
    applyStimulus(LSE0, 6'b000001, gap, tag);
    lvl = LJ;
    applyStimulus(LJ, 6'b000100, gap, {tag, "_eop"});
  endtask

  initial begin
    #1;
    checkValue("reset_async", obsVec(), 6'b0);
    #20;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    checkValue("reset_release", obsVec(), 6'b0);

    // Clean packet 0xA5
    applyStimulus(LJ, 6'b0, 1, "idle_j");
    sendSync(1, "clean_sync");
    sendByte(8'hA5, 1, "clean_data");
    sendEop(1, "clean");
    applyStimulus(LJ, 6'b0, 1, "clean_after");

    // Stuffed 0xFF
    sendSync(1, "stuff_sync");
    sendByte(8'hFF, 1, "stuff_data");
    sendEop(1, "stuff");

    // Seven consecutive ones
    sendSync(1, "viol_sync");
    for (int i = 0; i < 6; i++) applyStimulus(LK, 6'b110001, 1, "viol_ones");
    applyStimulus(LK, 6'b000010, 1, "viol_err");
    compared++;
    assert (dut.state_q === RX_ERROR) else begin
      mismatched++;
      $error("[TB] FAIL viol_state observed=%0d expected=%0d", dut.state_q, RX_ERROR);
    end
    for (int i = 0; i < 7; i++) applyStimulus(LJ, 6'b0, 1, "viol_recover");
    compared++;
    assert (dut.state_q === RX_ERROR) else begin
      mismatched++;
      $error("[TB] FAIL viol_still_err observed=%0d expected=%0d", dut.state_q, RX_ERROR);
    end
    applyStimulus(LJ, 6'b0, 1, "viol_recover8");
    compared++;
    assert (dut.state_q === RX_IDLE) else begin
      mismatched++;
      $error("[TB] FAIL viol_idle observed=%0d expected=%0d", dut.state_q, RX_IDLE);
    end
    lvl = LJ;

    // SYNC abort then a full packet
    applyStimulus(LK, 6'b0, 1, "abort");
    applyStimulus(LJ, 6'b0, 1, "abort");
    applyStimulus(LK, 6'b0, 1, "abort");
    applyStimulus(LJ, 6'b0, 1, "abort");
    applyStimulus(LSE0, 6'b0, 1, "abort_se0");
    applyStimulus(LJ, 6'b0, 1, "abort_j");
    sendSync(1, "abort_resync");
    sendByte(8'h3C, 1, "abort_data");
    sendEop(1, "abort");

    // Clean packet with sparse strobes
    sendSync(4, "gap_sync");
    sendByte(8'hA5, 4, "gap_data");
    sendEop(4, "gap");

    // Reset in the middle of a payload
    sendSync(1, "rst_sync");
    applyStimulus(LK, 6'b110001, 1, "rst_b0");
    applyStimulus(LJ, 6'b100001, 1, "rst_b1");
    applyStimulus(LJ, 6'b110001, 1, "rst_b2");
    #2;
    nRST = 1'b0;
    #1;
    checkValue("rst_midpkt", obsVec(), 6'b0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    checkValue("rst_after", obsVec(), 6'b0);
    applyStimulus(LJ, 6'b0, 1, "rst_nosync");
    applyStimulus(LK, 6'b0, 1, "rst_nosync");
    applyStimulus(LK, 6'b0, 1, "rst_nosync");
    applyStimulus(LJ, 6'b0, 1, "rst_nosync");
    applyStimulus(LK, 6'b0, 1, "rst_nosync");
    applyStimulus(LJ, 6'b0, 1, "rst_nosync");
    applyStimulus(LK, 6'b0, 1, "rst_nosync");
    applyStimulus(LJ, 6'b0, 1, "rst_nosync");
    applyStimulus(LJ, 6'b0, 1, "rst_nosync");

    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL queue_drain observed=%0d expected=0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
